// File: rtl/pcs_link_ctrl.sv
// PCS link bring-up controller: power-up sequencing, sync qualification,
// invalid code-group monitoring in LINK_UP and FAIL/retry handling.
module pcs_link_ctrl #(
    parameter int unsigned PWR_ON_CYC       = 4,
    parameter int unsigned SYNC_TIMEOUT_CYC = 1000,
    parameter int unsigned LINK_TIMER_CYC   = 16,
    parameter int unsigned WINDOW_CYC       = 256,
    parameter int unsigned ERR_THRESH       = 8
) (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        enable,
    input  logic        sync_status,
    input  logic        cg_invalid,
    output logic        power_on,
    output logic        pcs_reset,
    output logic        link_ok,
    output logic [2:0]  state,
    output logic [15:0] err_count,
    output logic [7:0]  retry_count
);

    localparam int unsigned MAX_A   = (PWR_ON_CYC > SYNC_TIMEOUT_CYC) ? PWR_ON_CYC
                                                                     : SYNC_TIMEOUT_CYC;
    localparam int unsigned MAX_B   = (LINK_TIMER_CYC > WINDOW_CYC) ? LINK_TIMER_CYC
                                                                    : WINDOW_CYC;
    localparam int unsigned TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned WERR_W  = $clog2(ERR_THRESH + 1);

    typedef enum logic [2:0] {
        StOff       = 3'd0,
        StPowerUp   = 3'd1,
        StWaitSync  = 3'd2,
        StLinkTimer = 3'd3,
        StLinkUp    = 3'd4,
        StFail      = 3'd5
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic [WERR_W-1:0]   r_win_err;
    logic [WERR_W-1:0]   w_win_err_nxt;
    logic [WERR_W-1:0]   w_win_err_inc;
    logic [15:0]         r_err_count;
    logic [7:0]          r_retry_count;
    logic                r_power_on;
    logic                r_pcs_reset;
    logic                r_link_ok;
    logic                w_power_on_nxt;
    logic                w_pcs_reset_nxt;
    logic                w_link_ok_nxt;
    logic                w_tmr_pwr;
    logic                w_tmr_sync;
    logic                w_tmr_link;
    logic                w_win_wrap;
    logic                w_err_hit;

    assign w_tmr_pwr     = (r_timer == TMR_W'(PWR_ON_CYC - 1));
    assign w_tmr_sync    = (r_timer == TMR_W'(SYNC_TIMEOUT_CYC - 1));
    assign w_tmr_link    = (r_timer == TMR_W'(LINK_TIMER_CYC - 1));
    assign w_win_wrap    = (r_timer == TMR_W'(WINDOW_CYC - 1));
    // The pulse landing on the wrap cycle still belongs to the closing window.
    assign w_win_err_inc = r_win_err + WERR_W'(cg_invalid);
    assign w_err_hit     = cg_invalid && (w_win_err_inc >= WERR_W'(ERR_THRESH));

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state       <= StOff;
            r_timer       <= '0;
            r_win_err     <= '0;
            r_err_count   <= '0;
            r_retry_count <= '0;
            r_power_on    <= 1'b0;
            r_pcs_reset   <= 1'b1;
            r_link_ok     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_win_err   <= w_win_err_nxt;
            r_power_on  <= w_power_on_nxt;
            r_pcs_reset <= w_pcs_reset_nxt;
            r_link_ok   <= w_link_ok_nxt;
            if (r_state == StLinkUp && cg_invalid && r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (w_state_nxt == StFail && r_state != StFail && r_retry_count != 8'hFF) begin
                r_retry_count <= r_retry_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = StOff;
        end else begin
            case (r_state)
                StOff:       w_state_nxt = StPowerUp;
                StPowerUp:   if (w_tmr_pwr) w_state_nxt = StWaitSync;
                StWaitSync: begin
                    if (sync_status)     w_state_nxt = StLinkTimer;
                    else if (w_tmr_sync) w_state_nxt = StFail;
                end
                StLinkTimer: begin
                    if (!sync_status)    w_state_nxt = StWaitSync;
                    else if (w_tmr_link) w_state_nxt = StLinkUp;
                end
                StLinkUp:    if (!sync_status || w_err_hit) w_state_nxt = StFail;
                StFail:      if (w_tmr_pwr) w_state_nxt = StWaitSync;
                default:     w_state_nxt = StOff;
            endcase
        end
    end

    always_comb begin
        w_timer_nxt   = r_timer + TMR_W'(1);
        w_win_err_nxt = w_win_err_inc;
        if (w_state_nxt != r_state || r_state == StOff) begin
            w_timer_nxt = '0;
        end else if (r_state == StLinkUp && w_win_wrap) begin
            w_timer_nxt = '0;
        end
        if (r_state != StLinkUp || w_state_nxt != StLinkUp || w_win_wrap) begin
            w_win_err_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so the registers track r_state.
    always_comb begin
        w_power_on_nxt  = 1'b0;
        w_pcs_reset_nxt = 1'b1;
        w_link_ok_nxt   = 1'b0;
        case (w_state_nxt)
            StPowerUp, StFail: begin
                w_power_on_nxt  = 1'b1;
                w_pcs_reset_nxt = 1'b1;
            end
            StWaitSync, StLinkTimer: begin
                w_power_on_nxt  = 1'b1;
                w_pcs_reset_nxt = 1'b0;
            end
            StLinkUp: begin
                w_power_on_nxt  = 1'b1;
                w_pcs_reset_nxt = 1'b0;
                w_link_ok_nxt   = 1'b1;
            end
            default: begin
                w_power_on_nxt  = 1'b0;
                w_pcs_reset_nxt = 1'b1;
                w_link_ok_nxt   = 1'b0;
            end
        endcase
    end

    assign power_on    = r_power_on;
    assign pcs_reset   = r_pcs_reset;
    assign link_ok     = r_link_ok;
    assign state       = r_state;
    assign err_count   = r_err_count;
    assign retry_count = r_retry_count;

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Self-checking bench for pcs_link_ctrl: directed bring-up/fail/reset sequence with
// randomized sync timing and randomized invalid code-group placement.
module tb_pcs_link_ctrl;

    localparam int PWR  = 4;
    localparam int TOUT = 1000;
    localparam int LT   = 16;
    localparam int WIN  = 256;
    localparam int THR  = 8;

    logic        Clk = 1'b0;
    logic        mr_main_reset;
    logic        enable;
    logic        sync_status;
    logic        cg_invalid;
    logic        power_on;
    logic        pcs_reset;
    logic        link_ok;
    logic [2:0]  state;
    logic [15:0] err_count;
    logic [7:0]  retry_count;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_err   = 0;
    int exp_retry = 0;

    always #5 Clk = ~Clk;

    pcs_link_ctrl dut (
        .Clk          (Clk),
        .mr_main_reset(mr_main_reset),
        .enable       (enable),
        .sync_status  (sync_status),
        .cg_invalid   (cg_invalid),
        .power_on     (power_on),
        .pcs_reset    (pcs_reset),
        .link_ok      (link_ok),
        .state        (state),
        .err_count    (err_count),
        .retry_count  (retry_count)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic bump_retry();
        if (exp_retry < 255) exp_retry++;
    endtask

    task automatic wait_state(input string tag, input int tgt, input int max_cyc,
                              output int n);
        n = 0;
        while (32'(state) != tgt && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, 32'(state), tgt);
    endtask

    // One window of LINK_UP: n_pulses invalid code-groups at random cycles, optionally
    // forcing the first and/or last cycle of the window. The reference is simply
    // "FAIL once the running count in this window reaches THR".
    task automatic run_window(input int n_pulses, input bit first_f, input bit last_f,
                              output bit failed);
        bit m [0:WIN-1];
        int lo, hi, left, p, cnt;
        for (int i = 0; i < WIN; i++) m[i] = 1'b0;
        left = n_pulses;
        if (first_f) begin m[0] = 1'b1; left--; end
        if (last_f) begin m[WIN-1] = 1'b1; left--; end
        lo = first_f ? 1 : 0;
        hi = last_f ? WIN - 2 : WIN - 1;
        while (left > 0) begin
            p = int'($urandom_range(hi, lo));
            if (!m[p]) begin m[p] = 1'b1; left--; end
        end
        failed = 1'b0;
        cnt = 0;
        for (int i = 0; i < WIN; i++) begin
            cg_invalid = m[i];
            step();
            if (m[i]) begin cnt++; exp_err++; end
            if (cnt >= THR) begin failed = 1'b1; bump_retry(); end
            chk("win_state", 32'(state), failed ? 4'd5 : 4'd4);
            if (failed) break;
        end
        cg_invalid = 1'b0;
        chk("win_err_count", 32'(err_count), exp_err);
    endtask

    initial begin
        int  n;
        int  d;
        bit  f;
        int  drops [3];

        mr_main_reset = 1'b1;
        enable        = 1'b0;
        sync_status   = 1'b0;
        cg_invalid    = 1'b0;
        #1 mr_main_reset = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_power_on", 32'(power_on), 0);
        chk("rst_pcs_reset", 32'(pcs_reset), 1);
        chk("rst_link_ok", 32'(link_ok), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_retry_count", 32'(retry_count), 0);
        @(posedge Clk);
        @(posedge Clk);
        #3 mr_main_reset = 1'b1;
        repeat (3) step();
        chk("off_idle", 32'(state), 0);

        // Bring-up with defaults.
        enable = 1'b1;
        step();
        chk("pwrup_state", 32'(state), 1);
        chk("pwrup_power_on", 32'(power_on), 1);
        chk("pwrup_pcs_reset", 32'(pcs_reset), 1);
        n = 0;
        while (pcs_reset === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("pwrup_len", n, PWR);
        chk("wsync_state", 32'(state), 2);
        d = int'($urandom_range(50, 0));
        repeat (d) step();
        chk("wsync_hold", 32'(state), 2);
        sync_status = 1'b1;
        step();
        chk("ltimer_state", 32'(state), 3);
        wait_state("link_up", 4, 40, n);
        chk("ltimer_len", n, LT);
        chk("linkup_link_ok", 32'(link_ok), 1);
        chk("linkup_pcs_reset", 32'(pcs_reset), 0);

        // 7 per window survives, also across a window boundary; 8th on the wrap cycle fails.
        run_window(7, 1'b0, 1'b0, f);
        chk("win0_nofail", 32'(f), 0);
        run_window(7, 1'b0, 1'b0, f);
        chk("win1_nofail", 32'(f), 0);
        run_window(7, 1'b0, 1'b1, f);
        chk("win2_nofail", 32'(f), 0);
        run_window(8, 1'b1, 1'b1, f);
        chk("win3_fail_at_wrap", 32'(f), 1);
        chk("fail_retry", 32'(retry_count), exp_retry);
        chk("fail_link_ok", 32'(link_ok), 0);
        chk("fail_pcs_reset", 32'(pcs_reset), 1);
        chk("fail_power_on", 32'(power_on), 1);

        // FAIL hold, then WAIT_SYNC timeout.
        sync_status = 1'b0;
        wait_state("fail_exit", 2, 20, n);
        chk("fail_len", n, PWR);
        chk("wsync_pcs_reset", 32'(pcs_reset), 0);
        wait_state("timeout", 5, TOUT + 100, n);
        chk("timeout_len", n, TOUT);
        bump_retry();
        chk("timeout_retry", 32'(retry_count), exp_retry);
        chk("timeout_pcs_reset", 32'(pcs_reset), 1);
        wait_state("fail2_exit", 2, 20, n);
        chk("fail2_len", n, PWR);

        // Sync loss during LINK_TIMER restarts qualification.
        drops[0] = 10;
        drops[1] = LT - 1;
        drops[2] = int'($urandom_range(LT - 2, 1));
        for (int k = 0; k < 3; k++) begin
            sync_status = 1'b1;
            step();
            chk("lt_enter", 32'(state), 3);
            repeat (drops[k]) step();
            chk("lt_before_drop", 32'(state), 3);
            sync_status = 1'b0;
            step();
            chk("lt_drop", 32'(state), 2);
        end
        sync_status = 1'b1;
        step();
        chk("lt_reenter", 32'(state), 3);
        wait_state("relink", 4, 40, n);
        chk("relink_len", n, LT);

        // Random placement: fail exactly at the 8th pulse of a window.
        run_window(7, 1'b0, 1'b0, f);
        chk("rwin0_nofail", 32'(f), 0);
        run_window(8, 1'b0, 1'b0, f);
        chk("rwin1_fail", 32'(f), 1);
        chk("rwin_retry", 32'(retry_count), exp_retry);

        // Repeated sync loss in LINK_UP drives retry_count into saturation.
        for (int i = 0; i < 256; i++) begin
            wait_state("sat_up", 4, 60, n);
            sync_status = 1'b0;
            step();
            bump_retry();
            chk("sat_fail_state", 32'(state), 5);
            chk("sat_retry", 32'(retry_count), exp_retry);
            sync_status = 1'b1;
        end
        chk("sat_retry_ff", 32'(retry_count), 255);

        // enable=0 from every state reaches OFF in one cycle.
        enable = 1'b0;
        step();
        chk("en_off_from5", 32'(state), 0);
        for (int t = 1; t <= 4; t++) begin
            enable = 1'b1;
            sync_status = 1'b0;
            if (t == 1) step();
            else wait_state("en_goto2", 2, 20, n);
            if (t >= 3) begin
                sync_status = 1'b1;
                wait_state("en_goto3", 3, 5, n);
            end
            if (t == 4) wait_state("en_goto4", 4, 40, n);
            chk("en_at_target", 32'(state), t);
            enable = 1'b0;
            step();
            chk("en_off_state", 32'(state), 0);
            chk("en_off_power_on", 32'(power_on), 0);
            chk("en_off_pcs_reset", 32'(pcs_reset), 1);
            chk("en_off_link_ok", 32'(link_ok), 0);
        end

        // Asynchronous reset in LINK_UP.
        enable = 1'b1;
        sync_status = 1'b1;
        wait_state("rst_goto4", 4, 60, n);
        chk("rst_pre_link_ok", 32'(link_ok), 1);
        mr_main_reset = 1'b0;
        #2;
        chk("arst_state", 32'(state), 0);
        chk("arst_power_on", 32'(power_on), 0);
        chk("arst_pcs_reset", 32'(pcs_reset), 1);
        chk("arst_link_ok", 32'(link_ok), 0);
        chk("arst_err_count", 32'(err_count), 0);
        chk("arst_retry_count", 32'(retry_count), 0);
        enable = 1'b0;
        step();
        mr_main_reset = 1'b1;
        repeat (3) step();
        chk("post_rst_wait", 32'(state), 0);
        enable = 1'b1;
        step();
        chk("post_rst_pwrup", 32'(state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_link_ctrl.md
PCS_LINK_CTRL -- requirements
Module: pcs_link_ctrl

Interface
REQ-001 The block SHALL have parameter PWR_ON_CYC, default 4, giving the power-up and PCS-reset hold length in cycles (>=1).
REQ-002 The block SHALL have parameter SYNC_TIMEOUT_CYC, default 1000, giving the maximum cycles in WAIT_SYNC before FAIL.
REQ-003 The block SHALL have parameter LINK_TIMER_CYC, default 16, giving the consecutive sync_status=1 cycles required for link-up.
REQ-004 The block SHALL have parameter WINDOW_CYC, default 256, giving the invalid-code-group monitoring window length in LINK_UP.
REQ-005 The block SHALL have parameter ERR_THRESH, default 8, giving the number of invalid code-groups within one window that forces FAIL.
REQ-006 Port Clk SHALL be an input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-007 Port mr_main_reset SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-008 Port enable SHALL be an input, 1 bit, link bring-up request.
REQ-009 Port sync_status SHALL be an input, 1 bit, code-group alignment indication from the synchronizer.
REQ-010 Port cg_invalid SHALL be an input, 1 bit, one-cycle pulse per invalid received 10-bit code-group.
REQ-011 Port power_on SHALL be an output, 1 bit, driving the receptor/synchronizer power_on.
REQ-012 Port pcs_reset SHALL be an output, 1 bit, active-high hold-in-reset for the receive path.
REQ-013 Port link_ok SHALL be an output, 1 bit, link established.
REQ-014 Port state SHALL be an output, 3 bits, current FSM state code.
REQ-015 Port err_count SHALL be an output, 16 bits, total invalid code-groups seen in LINK_UP, saturating.
REQ-016 Port retry_count SHALL be an output, 8 bits, number of FAIL entries, saturating.

Function
REQ-017 The FSM SHALL use the state codes OFF=0, POWER_UP=1, WAIT_SYNC=2, LINK_TIMER=3, LINK_UP=4, FAIL=5; codes 6-7 SHALL return to OFF on the next edge.
REQ-018 All outputs SHALL be registered, with values corresponding to the current state register.
REQ-019 In OFF, outputs SHALL be power_on=0, pcs_reset=1, link_ok=0; enable=1 SHALL move the FSM to POWER_UP.
REQ-020 In POWER_UP, outputs SHALL be power_on=1, pcs_reset=1; the FSM SHALL remain exactly PWR_ON_CYC cycles, then enter WAIT_SYNC.
REQ-021 In WAIT_SYNC, outputs SHALL be power_on=1, pcs_reset=0; sync_status=1 SHALL move to LINK_TIMER; otherwise, after SYNC_TIMEOUT_CYC cycles in the state, the FSM SHALL enter FAIL.
REQ-022 In LINK_TIMER, the FSM SHALL enter LINK_UP after LINK_TIMER_CYC consecutive cycles with sync_status=1; any sync_status=0 SHALL return it to WAIT_SYNC with the timeout counter restarted.
REQ-023 In LINK_UP, link_ok SHALL be 1; sync_status=0 SHALL move to FAIL on the next edge.
REQ-024 In LINK_UP, the block SHALL count cg_invalid pulses within consecutive WINDOW_CYC windows; the count SHALL clear at window wrap; reaching ERR_THRESH SHALL enter FAIL.
REQ-025 If the window wrap and the ERR_THRESH-th pulse occur in the same cycle, the pulse SHALL count and FAIL SHALL be taken.
REQ-026 err_count SHALL increment per cg_invalid only while in LINK_UP, and SHALL hold at 16'hFFFF.
REQ-027 Entry to FAIL SHALL increment retry_count by 1, holding at 8'hFF.
REQ-028 In FAIL, outputs SHALL be power_on=1, pcs_reset=1, link_ok=0; the FSM SHALL hold PWR_ON_CYC cycles, then enter WAIT_SYNC.
REQ-029 enable=0 in any state SHALL move the FSM to OFF on the next edge, taking priority over all other transitions.
REQ-030 Every state timer SHALL restart from 0 on state entry.

Reset
REQ-031 When mr_main_reset=0, the block SHALL immediately, without waiting for a clock edge, set state=OFF, power_on=0, pcs_reset=1, link_ok=0, err_count=0, retry_count=0, and clear all timers.
REQ-032 Reset asserted mid-operation, including in LINK_UP, SHALL abort to OFF; after release, the FSM SHALL wait for enable.

Verification
REQ-033 Directed test (defaults): with reset released and enable=1, power_on SHALL rise, pcs_reset SHALL fall 4 cycles later, sync_status=1 SHALL follow, and link_ok SHALL be 1 after 16 cycles of sync_status=1, with state=4.
REQ-034 Directed test: with sync_status held 0, the FSM SHALL reach FAIL after 1000 cycles in WAIT_SYNC, set retry_count=1, assert pcs_reset for 4 cycles, then return to WAIT_SYNC.
REQ-035 Directed test: if sync_status drops at cycle 10 of LINK_TIMER, state SHALL return to 2, and link-up SHALL require a fresh 16 consecutive cycles.
REQ-036 Directed test: in LINK_UP, 8 cg_invalid pulses within one window SHALL cause FAIL with err_count=8, while 7 pulses per window SHALL keep link_ok=1.
REQ-037 Directed test: mr_main_reset=0 asserted mid-LINK_UP SHALL force outputs to reset values immediately, and enable=0 SHALL reach OFF in 1 cycle from any state.
